// File: rtl/data_cache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache.
// Word-address/data widths and the controller state encoding.
package data_cache_pkg;

    localparam int WORD_ADDR_W = 6;
    localparam int DATA_W      = 32;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FETCH,
        UPDATE
    } state_t;

endpackage

// File: rtl/data_cache_array.sv
// Line storage for the data cache: valid/dirty/tag/data per line,
// combinational read at one index, synchronous hit-write or refill.
module data_cache_array
    import data_cache_pkg::*;
#(
    parameter int IDX_W = 3,
    parameter int TAG_W = WORD_ADDR_W - IDX_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [IDX_W-1:0]  index,
    output logic              line_valid,
    output logic              line_dirty,
    output logic [TAG_W-1:0]  line_tag,
    output logic [DATA_W-1:0] line_data,
    input  logic              write_en,
    input  logic [DATA_W-1:0] write_data,
    input  logic              fill_en,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic [DATA_W-1:0] fill_data
);

    localparam int LINES = 1 << IDX_W;

    logic [LINES-1:0]  valid_bits;
    logic [LINES-1:0]  dirty_bits;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES];

    assign line_valid = valid_bits[index];
    assign line_dirty = dirty_bits[index];
    assign line_tag   = tag_mem[index];
    assign line_data  = data_mem[index];

    // Clearing the valid bits is enough to discard everything, including dirty data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_bits <= '0;
            dirty_bits <= '0;
        end else if (fill_en) begin
            valid_bits[index] <= 1'b1;
            dirty_bits[index] <= 1'b0;
        end else if (write_en) begin
            dirty_bits[index] <= 1'b1;
        end
    end

    // NOTE: the tag/data arrays have no reset; valid gates their use, and leaving
    // them unreset lets them map onto plain RAM.
    always_ff @(posedge clock) begin
        if (fill_en) begin
            tag_mem[index]  <= fill_tag;
            data_mem[index] <= fill_data;
        end else if (write_en) begin
            data_mem[index] <= write_data;
        end
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache, one word per line.
// Optional hit/miss counters are enabled with macro DATA_CACHE_STATS_EN.
module data_cache
    import data_cache_pkg::*;
#(
    parameter int IDX_W = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cpu_read,
    input  logic                   cpu_write,
    input  logic [7:0]             cpu_address,
    input  logic [DATA_W-1:0]      cpu_writedata,
    output logic [DATA_W-1:0]      cpu_readdata,
    output logic                   cpu_busywait,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [WORD_ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0]      mem_writedata,
    input  logic [DATA_W-1:0]      mem_readdata,
    input  logic                   mem_busywait
`ifdef DATA_CACHE_STATS_EN
    ,
    output logic [15:0]            hit_count,
    output logic [15:0]            miss_count
`endif
);

    localparam int TAG_W = WORD_ADDR_W - IDX_W;

    state_t state;
    state_t next_state;

    logic [WORD_ADDR_W-1:0] word_address;
    logic [IDX_W-1:0]       index;
    logic [TAG_W-1:0]       tag;
    logic                   access;
    logic                   hit;
    logic                   miss;
    logic                   line_valid;
    logic                   line_dirty;
    logic [TAG_W-1:0]       line_tag;
    logic [DATA_W-1:0]      line_data;
    logic                   write_en;
    logic                   fill_en;
    logic                   unused_addr_bits;

    assign word_address     = cpu_address[7:2];
    assign unused_addr_bits = ^cpu_address[1:0];
    assign index            = word_address[IDX_W-1:0];
    assign tag              = word_address[WORD_ADDR_W-1:IDX_W];

    // Read and write together is treated as no request at all.
    assign access = cpu_read ^ cpu_write;
    assign hit    = line_valid && (line_tag == tag);
    assign miss   = access && !hit;

    data_cache_array #(
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clock      (clock),
        .reset      (reset),
        .index      (index),
        .line_valid (line_valid),
        .line_dirty (line_dirty),
        .line_tag   (line_tag),
        .line_data  (line_data),
        .write_en   (write_en),
        .write_data (cpu_writedata),
        .fill_en    (fill_en),
        .fill_tag   (tag),
        .fill_data  (mem_readdata)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of block evaluation order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (miss) begin
                    next_state = (line_valid && line_dirty) ? WRITEBACK : FETCH;
                end
            end
            WRITEBACK: begin
                if (!mem_busywait) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                if (!mem_busywait) begin
                    next_state = UPDATE;
                end
            end
            UPDATE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        cpu_busywait  = 1'b0;
        cpu_readdata  = '0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = word_address;
        mem_writedata = line_data;
        write_en      = 1'b0;
        fill_en       = 1'b0;
        unique case (state)
            IDLE: begin
                cpu_busywait = miss;
                if (cpu_read && !cpu_write && hit) begin
                    cpu_readdata = line_data;
                end
                write_en = cpu_write && !cpu_read && hit;
            end
            WRITEBACK: begin
                cpu_busywait = 1'b1;
                mem_write    = 1'b1;
                mem_address  = {line_tag, index};
            end
            FETCH: begin
                cpu_busywait = 1'b1;
                mem_read     = 1'b1;
            end
            UPDATE: begin
                cpu_busywait = 1'b1;
                fill_en      = 1'b1;
            end
            default: begin
                cpu_busywait = 1'b1;
            end
        endcase
    end

`ifdef DATA_CACHE_STATS_EN
    // A request that missed is not counted again when it finally completes as a hit.
    logic miss_seen;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
            miss_seen  <= 1'b0;
        end else if (state == IDLE && access) begin
            if (!hit) begin
                miss_count <= miss_count + 16'd1;
                miss_seen  <= 1'b1;
            end else begin
                if (!miss_seen) begin
                    hit_count <= hit_count + 16'd1;
                end
                miss_seen <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: a line-level reference model predicts CPU
// responses, stall lengths and memory traffic; monitors compare as the DUT responds.
module tb_data_cache;
    import data_cache_pkg::*;

    localparam int IDX_W = 3;
    localparam int LINES = 1 << IDX_W;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_read;
    logic        cpu_write;
    logic [7:0]  cpu_address;
    logic [31:0] cpu_writedata;
    logic [31:0] cpu_readdata;
    logic        cpu_busywait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;
`ifdef DATA_CACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    always #5 clock = ~clock;

    data_cache #(.IDX_W(IDX_W)) dut (
        .clock         (clock),
        .reset         (reset),
        .cpu_read      (cpu_read),
        .cpu_write     (cpu_write),
        .cpu_address   (cpu_address),
        .cpu_writedata (cpu_writedata),
        .cpu_readdata  (cpu_readdata),
        .cpu_busywait  (cpu_busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
`ifdef DATA_CACHE_STATS_EN
        ,
        .hit_count     (hit_count),
        .miss_count    (miss_count)
`endif
    );

    // Backing memory: each access holds busywait high for mem_wait_cfg cycles.
    logic [31:0] tb_mem [64];
    int unsigned mem_wait_cfg = 0;
    int unsigned wait_cnt = 0;

    assign mem_busywait = (mem_read || mem_write) && (wait_cnt != 0);
    assign mem_readdata = tb_mem[mem_address];

    always @(posedge clock) begin
        if (!(mem_read || mem_write) || !mem_busywait) wait_cnt <= mem_wait_cfg;
        else wait_cnt <= wait_cnt - 1;
        if (mem_write && !mem_busywait) tb_mem[mem_address] <= mem_writedata;
    end

    // Reference model of the cache contents and of main memory.
    bit          ref_valid [LINES];
    bit          ref_dirty [LINES];
    int          ref_tag   [LINES];
    logic [31:0] ref_data  [LINES];
    logic [31:0] ref_mem   [64];

    typedef struct {
        bit          is_write;
        logic [31:0] rdata;
        int          stall;
    } cpu_exp_t;

    typedef struct {
        bit          is_write;
        logic [5:0]  addr;
        logic [31:0] wdata;
    } mem_exp_t;

    cpu_exp_t cpu_q[$];
    mem_exp_t mem_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic finish_test();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) begin
            ref_valid[i] = 1'b0;
            ref_dirty[i] = 1'b0;
        end
    endtask

    // Predict the outcome of one CPU access, then drive it until the cache releases it.
    // Stall = busy cycles seen by the CPU: the detecting cycle, 1+wait per memory
    // access, plus the refill cycle.
    task automatic issue(input bit is_write, input logic [7:0] addr,
                         input logic [31:0] wdata, input int unsigned wcfg);
        logic [5:0] w;
        int         idx;
        int         tg;
        int         victim;
        int         cyc;
        cpu_exp_t   ce;
        mem_exp_t   me;
        w        = addr[7:2];
        idx      = int'(w) % LINES;
        tg       = int'(w) / LINES;
        ce.stall = 0;
        if (!(ref_valid[idx] && ref_tag[idx] == tg)) begin
            ce.stall = 1;
            if (ref_valid[idx] && ref_dirty[idx]) begin
                victim        = ref_tag[idx] * LINES + idx;
                me.is_write   = 1'b1;
                me.addr       = 6'(victim);
                me.wdata      = ref_data[idx];
                mem_q.push_back(me);
                ref_mem[victim] = ref_data[idx];
                ce.stall     += 1 + int'(wcfg);
            end
            me.is_write    = 1'b0;
            me.addr        = w;
            me.wdata       = '0;
            mem_q.push_back(me);
            ref_valid[idx] = 1'b1;
            ref_dirty[idx] = 1'b0;
            ref_tag[idx]   = tg;
            ref_data[idx]  = ref_mem[w];
            ce.stall      += 2 + int'(wcfg);
        end
        ce.is_write = is_write;
        ce.rdata    = ref_data[idx];
        if (is_write) begin
            ref_data[idx]  = wdata;
            ref_dirty[idx] = 1'b1;
        end
        cpu_q.push_back(ce);

        mem_wait_cfg  = wcfg;
        cpu_address   = addr;
        cpu_writedata = wdata;
        cpu_read      = !is_write;
        cpu_write     = is_write;
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
        end while (cpu_busywait && cyc < 100);
        if (cpu_busywait) begin
            check("cpu_busywait_timeout", 32'(cpu_busywait), 32'd0);
            finish_test();
        end
        @(posedge clock);
        #1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
    endtask

    // Read and write held together for a few cycles must do nothing at all.
    task automatic issue_noop(input logic [7:0] addr, input logic [31:0] wdata);
        cpu_address   = addr;
        cpu_writedata = wdata;
        cpu_read      = 1'b1;
        cpu_write     = 1'b1;
        repeat (2) begin
            @(negedge clock);
            check("noop_busywait", 32'(cpu_busywait), 32'd0);
            check("noop_mem_read", 32'(mem_read), 32'd0);
            check("noop_mem_write", 32'(mem_write), 32'd0);
        end
        @(posedge clock);
        #1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
    endtask

    // CPU-side monitor: one completion per cycle where a request is seen unstalled.
    int stall_cnt = 0;
    always @(negedge clock) begin
        if (reset || !(cpu_read ^ cpu_write)) begin
            stall_cnt <= 0;
        end else if (cpu_busywait) begin
            stall_cnt <= stall_cnt + 1;
        end else begin
            if (cpu_q.size() == 0) begin
                check("cpu_unexpected_completion", 32'd1, 32'd0);
            end else begin
                cpu_exp_t ce;
                ce = cpu_q.pop_front();
                if (!ce.is_write) check("cpu_readdata", cpu_readdata, ce.rdata);
                check("stall_cycles", 32'(stall_cnt), 32'(ce.stall));
            end
            stall_cnt <= 0;
        end
    end

    // Memory-side monitor: checks each memory access as it completes.
    always @(negedge clock) begin
        if (!reset && (mem_read || mem_write)) begin
            check("mem_read_write_exclusive", 32'(mem_read && mem_write), 32'd0);
            if (!mem_busywait) begin
                if (mem_q.size() == 0) begin
                    check("mem_unexpected_access", 32'd1, 32'd0);
                end else begin
                    mem_exp_t me;
                    me = mem_q.pop_front();
                    check("mem_is_write", 32'(mem_write), 32'(me.is_write));
                    check("mem_address", 32'(mem_address), 32'(me.addr));
                    if (me.is_write) check("mem_writedata", mem_writedata, me.wdata);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = $urandom;
            tb_mem[i]  = ref_mem[i];
        end
        ref_mem[5] = 32'hDEAD_BEEF;
        tb_mem[5]  = 32'hDEAD_BEEF;
        for (int i = 0; i < LINES; i++) begin
            ref_tag[i]  = 0;
            ref_data[i] = '0;
        end
        model_reset();

        reset         = 1'b1;
        cpu_read      = 1'b0;
        cpu_write     = 1'b0;
        cpu_address   = '0;
        cpu_writedata = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_mem_read", 32'(mem_read), 32'd0);
        check("reset_mem_write", 32'(mem_write), 32'd0);
        check("reset_cpu_readdata", cpu_readdata, 32'd0);
        check("reset_cpu_busywait", 32'(cpu_busywait), 32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Cold read miss of 0x14, then a zero-stall repeat.
        issue(1'b0, 8'h14, 32'h0, 1);
        issue(1'b0, 8'h14, 32'h0, 0);
        // Write hit, then read it back.
        issue(1'b1, 8'h14, 32'hA5A5_A5A5, 2);
        issue(1'b0, 8'h14, 32'h0, 0);
        // Conflict on the same line: dirty victim written back, then refill.
        issue(1'b0, 8'h34, 32'h0, 2);
`ifdef DATA_CACHE_STATS_EN
        check("stats_hit_count", 32'(hit_count), 32'd3);
        check("stats_miss_count", 32'(miss_count), 32'd2);
`endif

        // Both strobes high, aimed at the resident line; its contents must survive.
        issue_noop(8'h34, 32'h1111_2222);
        issue_noop(8'h14, 32'h3333_4444);
        issue(1'b0, 8'h34, 32'h0, 0);

        // Dirty a line, then reset during a fetch: dirty data is lost, lines re-miss.
        issue(1'b1, 8'h04, 32'h1234_5678, 1);
        mem_wait_cfg = 6;
        cpu_address  = 8'h18;
        cpu_read     = 1'b1;
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
        end while (!mem_read && cyc < 20);
        check("fetch_started", 32'(mem_read), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("reset_drops_mem_read", 32'(mem_read), 32'd0);
        check("reset_drops_mem_write", 32'(mem_write), 32'd0);
        cpu_read = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        @(posedge clock);
        #1;
        issue(1'b0, 8'h18, 32'h0, 1);
        issue(1'b0, 8'h04, 32'h0, 0);

        // Randomised traffic, including no-op requests and ignored low address bits.
        for (int n = 0; n < 300; n++) begin
            logic [7:0] a;
            a = {6'($urandom_range(0, 63)), 2'($urandom)};
            if ($urandom_range(0, 9) == 0) begin
                issue_noop(a, $urandom);
            end else begin
                issue(1'($urandom), a, $urandom, $urandom_range(0, 3));
            end
        end

        repeat (2) @(posedge clock);
        #1;
        check("cpu_queue_drained", 32'(cpu_q.size()), 32'd0);
        check("mem_queue_drained", 32'(mem_q.size()), 32'd0);
        finish_test();
    end

endmodule
